mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Memory controller: the responder end of the MEM-stage load/store interface and the IF-stage fetch interface. Arbitrates both requesters onto the single byte-wide RAM/IO port and serialises 1/2/4-byte accesses into per-byte RAM cycles. It assembles read data and returns it with a one-cycle done pulse. It also raises per-requester stall requests to the stall controller while an access is outstanding.

## Interface
Parameters: none; widths come from shared `config.v` macros (`RegBus` = 32 bits).
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global ready; low freezes all state
- if_req  in  1  fetch request, held until if_done
- if_addr  in  32  fetch byte address
- if_done  out  1  one-cycle pulse: if_inst valid
- if_inst  out  32  fetched word, little-endian
- mem_req  in  1  load/store request, held until mem_done
- mem_we  in  1  1 = store, 0 = load
- mem_len  in  2  0 = byte, 1 = half, 3 = word (bytes = mem_len+1); 2 is illegal
- mem_addr  in  32  access byte address
- mem_wdata  in  32  store data, low bytes used
- mem_done  out  1  one-cycle pulse: access complete
- mem_rdata  out  32  load data, zero-filled above len (MEM stage sign-extends)
- stall_req_if  out  1  if_req & ~if_done (combinational)
- stall_req_mem  out  1  mem_req & ~mem_done (combinational)
- ram_din  in  8  RAM read byte; valid one cycle after its address
- ram_dout  out  8  RAM write byte
- ram_a  out  32  RAM byte address
- ram_wr  out  1  1 = write this cycle
- io_buffer_full  in  1  IO write buffer full

## Operation
- States: IDLE, READ, WRITE, DONE; byte counter cnt (3 bits); latched addr, len n (1..4), data buffer, and owner (IF/MEM).
- IDLE: if mem_req, latch MEM request (priority over IF); the next state is WRITE if mem_we, else READ. Else, if if_req, latch IF with n = 4; the next state is READ. Else stay. cnt ← 0.
- READ: ram_a = addr+cnt while cnt < n; ram_wr = 0. When cnt ≥ 1, capture ram_din into buffer byte cnt−1. When cnt = n (last capture), go to DONE; otherwise cnt+1.
- WRITE: ram_a = addr+cnt, ram_dout = wdata byte cnt, ram_wr = 1. At cnt = n−1, go to DONE.
  - IO hold: if addr+cnt has bits [17:16] = 2'b11 and io_buffer_full = 1, then ram_wr = 0 and cnt holds.
- DONE: the owner's done is 1 for exactly this cycle. rdata/inst = buffer, upper bytes zero; stores return zero. Requests are ignored. Next state is IDLE.
- rdata/inst hold their value until the next DONE.
- In IDLE and DONE, ram_a = 0 and ram_wr = 0.

## Timing
- Reset (sync, at the edge with rst = 1): state IDLE, cnt 0, buffer 0, if_done/mem_done 0, if_inst/mem_rdata 0. ram_wr, ram_a and ram_dout are forced to 0 combinationally while rst = 1.
- Reset mid-access abandons it. A store already partially written is not rolled back.
- rdy = 0: no state or counter change and ram_wr forced 0. ram_a is held, so the pending read byte is re-presented when rdy returns.
- Latency, request first seen high in IDLE at cycle c:
  - Read of n bytes: READ occupies c+1 .. c+n+1; done in cycle c+n+2. A word fetch is done at c+6.
  - Store of n bytes, no IO hold: WRITE occupies c+1 .. c+n; done in c+n+1.
- Simultaneous if_req and mem_req: MEM is served first. IF stays pending, stall_req_if stays high, and IF is served from the IDLE after DONE.
- Requesters drop req at the edge ending the done cycle. The DONE state guarantees no re-issue.
- stall_req_* is combinational and reaches the stall controller in the same cycle.

## Structure
- Add to `config.v`: state encodings (IDLE/READ/WRITE/DONE), the IO address match (bits [17:16] = 2'b11), and the len codes.
- Single module, no sub-module. Byte-lane insert/extract is inline indexing by cnt.

## Test plan
- Word fetch: if_req = 1, if_addr = 0x100, RAM[0x100..0x103] = 13,05,00,00.
  - ram_a steps through 0x100..0x103.
  - if_done pulses at c+6 with if_inst = 0x00000513.
  - stall_req_if is high until that cycle.
- Byte load: mem_len = 0, addr 0x2001, RAM = 0x80. Expect mem_rdata = 0x00000080 at c+3.
- Half store: mem_len = 1, mem_wdata = 0xAABBCCDD, addr 0x40.
  - ram_wr is high two cycles: (0x40, 0xDD), then (0x41, 0xCC).
  - mem_done at c+3.
- Arbitration: if_req and mem_req (word load) both rise in the same cycle.
  - MEM completes first.
  - IF starts in the IDLE after DONE.
  - stall_req_if stays 1 throughout.
- IO hold: store byte 0x41 to 0x30000 with io_buffer_full high 3 cycles.
  - ram_wr stays 0 for those 3 cycles.
  - Then one write of 0x41; mem_done follows.
- Reset/rdy:
  - rdy low 2 cycles mid-fetch: same if_inst, done delayed by 2 cycles.
  - rst during WRITE cnt = 1: ram_wr 0 that cycle, IDLE next, no done.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serialising memory controller.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   typedef enum logic {
      OWN_IF  = 1'b0,
      OWN_MEM = 1'b1
   } owner_t;

   localparam logic [1:0] LEN_BYTE = 2'd0;
   localparam logic [1:0] LEN_HALF = 2'd1;
   localparam logic [1:0] LEN_WORD = 2'd3;

   // Address bits [17:16] select the IO write buffer.
   localparam logic [1:0] IO_SEL = 2'b11;

   function automatic logic is_io(input logic [31:0] a);
      return a[17:16] == IO_SEL;
   endfunction

   // Byte count for a length code; the illegal code 2 maps to 3 bytes.
   function automatic logic [2:0] len_to_n(input logic [1:0] len);
      logic [2:0] n;
      case (len)
         LEN_BYTE: n = 3'd1;
         LEN_HALF: n = 3'd2;
         LEN_WORD: n = 3'd4;
         default:  n = 3'd3;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Fetch, load/store and byte-wide RAM/IO signals of the memory controller.
interface mem_ctrl_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_done;
   logic [31:0] if_inst;
   logic        mem_req;
   logic        mem_we;
   logic [1:0]  mem_len;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_done;
   logic [31:0] mem_rdata;
   logic        stall_req_if;
   logic        stall_req_mem;
   logic [7:0]  ram_din;
   logic [7:0]  ram_dout;
   logic [31:0] ram_a;
   logic        ram_wr;
   logic        io_buffer_full;

   modport slave (
      input  if_req, if_addr, mem_req, mem_we, mem_len, mem_addr, mem_wdata,
             ram_din, io_buffer_full,
      output if_done, if_inst, mem_done, mem_rdata, stall_req_if, stall_req_mem,
             ram_dout, ram_a, ram_wr
   );

   modport master (
      output if_req, if_addr, mem_req, mem_we, mem_len, mem_addr, mem_wdata,
             ram_din, io_buffer_full,
      input  if_done, if_inst, mem_done, mem_rdata, stall_req_if, stall_req_mem,
             ram_dout, ram_a, ram_wr
   );
endinterface

// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates fetch and load/store requests onto a
// byte-wide RAM/IO port and serialises 1/2/4-byte accesses.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting; latches MEM request (priority) or IF request
//   ST_READ  | presents addr+cnt, captures ram_din one cycle later
//   ST_WRITE | writes wdata byte cnt to addr+cnt, holds on full IO buffer
//   ST_DONE  | owner's done pulse; requests ignored; back to idle
module mem_ctrl
   import mem_ctrl_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      rdy,
   mem_ctrl_if.slave bus
);

   state_t      state, state_nx;
   owner_t      owner, owner_nx;
   logic [2:0]  cnt, cnt_nx;
   logic [2:0]  n, n_nx;
   logic        we, we_nx;
   logic [31:0] addr, addr_nx;
   logic [31:0] wdata, wdata_nx;
   logic [31:0] rbuf, rbuf_nx;
   logic [31:0] if_inst_q, mem_rdata_q;
   logic [31:0] ram_a_hold;

   logic [31:0] a_cur;
   logic [31:0] ram_a_c;
   logic [7:0]  dout_c;
   logic        wr_c;
   logic        io_hold;
   logic [1:0]  idx;

   // Next-state, datapath update and RAM port drive for the current state.
   always_comb begin
      state_nx = state;
      owner_nx = owner;
      cnt_nx   = cnt;
      n_nx     = n;
      we_nx    = we;
      addr_nx  = addr;
      wdata_nx = wdata;
      rbuf_nx  = rbuf;
      ram_a_c  = '0;
      dout_c   = '0;
      wr_c     = 1'b0;
      io_hold  = 1'b0;
      a_cur    = addr + {29'd0, cnt};
      idx      = cnt[1:0] - 2'd1;

      case (state)
         ST_IDLE: begin
            cnt_nx = '0;
            if (bus.mem_req) begin
               owner_nx = OWN_MEM;
               we_nx    = bus.mem_we;
               addr_nx  = bus.mem_addr;
               n_nx     = len_to_n(bus.mem_len);
               wdata_nx = bus.mem_wdata;
               rbuf_nx  = '0;
               state_nx = bus.mem_we ? ST_WRITE : ST_READ;
            end else if (bus.if_req) begin
               owner_nx = OWN_IF;
               we_nx    = 1'b0;
               addr_nx  = bus.if_addr;
               n_nx     = 3'd4;
               rbuf_nx  = '0;
               state_nx = ST_READ;
            end
         end
         ST_READ: begin
            if (cnt < n) ram_a_c = a_cur;
            // Byte presented in the previous cycle arrives now.
            if (cnt != 3'd0) rbuf_nx[{idx, 3'b000} +: 8] = bus.ram_din;
            if (cnt >= n) state_nx = ST_DONE;
            else          cnt_nx   = cnt + 3'd1;
         end
         ST_WRITE: begin
            ram_a_c = a_cur;
            dout_c  = wdata[{cnt[1:0], 3'b000} +: 8];
            io_hold = is_io(a_cur) && bus.io_buffer_full;
            wr_c    = !io_hold;
            if (!io_hold) begin
               if (cnt == n - 3'd1) state_nx = ST_DONE;
               else                 cnt_nx   = cnt + 3'd1;
            end
         end
         ST_DONE: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // State and datapath registers; everything freezes while rdy is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         owner       <= OWN_IF;
         cnt         <= '0;
         n           <= '0;
         we          <= 1'b0;
         addr        <= '0;
         wdata       <= '0;
         rbuf        <= '0;
         if_inst_q   <= '0;
         mem_rdata_q <= '0;
         ram_a_hold  <= '0;
      end else if (rdy) begin
         state      <= state_nx;
         owner      <= owner_nx;
         cnt        <= cnt_nx;
         n          <= n_nx;
         we         <= we_nx;
         addr       <= addr_nx;
         wdata      <= wdata_nx;
         rbuf       <= rbuf_nx;
         // Last presented address; re-shown during a freeze so the byte in
         // flight is fetched again before capture resumes.
         ram_a_hold <= ram_a_c;
         if (state_nx == ST_DONE && state != ST_DONE) begin
            if (owner == OWN_IF) if_inst_q   <= rbuf_nx;
            else                 mem_rdata_q <= we ? '0 : rbuf_nx;
         end
      end
   end

   assign bus.if_done       = (state == ST_DONE) && (owner == OWN_IF);
   assign bus.mem_done      = (state == ST_DONE) && (owner == OWN_MEM);
   assign bus.if_inst       = if_inst_q;
   assign bus.mem_rdata     = mem_rdata_q;
   assign bus.stall_req_if  = bus.if_req  && !bus.if_done;
   assign bus.stall_req_mem = bus.mem_req && !bus.mem_done;

   assign bus.ram_a    = rst ? '0 : (rdy ? ram_a_c : ram_a_hold);
   assign bus.ram_dout = rst ? '0 : dout_c;
   assign bus.ram_wr   = !rst && rdy && wr_c;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: vector table plus multi-cycle sequences.
module tb_mem_ctrl;

   typedef struct {
      bit          is_if;
      bit          we;
      logic [1:0]  len;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rdy = 1'b1;

   mem_ctrl_if bus();

   mem_ctrl dut (
      .clk (clk),
      .rst (rst),
      .rdy (rdy),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   vec_t vecs [14];

   bit [7:0] wr_val [0:65535];
   bit       wr_vld [0:65535];
   logic [31:0] alog [$];
   logic [39:0] wlog [$];

   function automatic logic [7:0] init_byte(input logic [15:0] a);
      case (a)
         16'h0100: return 8'h13;
         16'h0101: return 8'h05;
         16'h2001: return 8'h80;
         16'h0200: return 8'h11;
         16'h0201: return 8'h22;
         16'h0202: return 8'h33;
         16'h0203: return 8'h44;
         default:  return 8'h00;
      endcase
   endfunction

   // RAM model: one-cycle read latency, write on ram_wr.
   always @(posedge clk) begin
      bus.ram_din <= wr_vld[bus.ram_a[15:0]] ? wr_val[bus.ram_a[15:0]]
                                             : init_byte(bus.ram_a[15:0]);
      if (bus.ram_wr) begin
         wr_val[bus.ram_a[15:0]] <= bus.ram_dout;
         wr_vld[bus.ram_a[15:0]] <= 1'b1;
      end
   end

   // Address and committed-write trace.
   always @(posedge clk) begin
      if (bus.ram_a != 32'd0) alog.push_back(bus.ram_a);
      if (bus.ram_wr) wlog.push_back({bus.ram_a, bus.ram_dout});
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic do_txn(input vec_t v, input int id);
      int k;
      int n;
      bit seen;
      bit stall_ok;
      bit trace_ok;
      bit wr_ok;
      logic d;
      logic s;
      logic [31:0] got;
      n = int'(v.len) + 1;
      alog.delete();
      wlog.delete();
      if (v.is_if) begin
         bus.if_addr = v.addr;
         bus.if_req  = 1'b1;
      end else begin
         bus.mem_we    = v.we;
         bus.mem_len   = v.len;
         bus.mem_addr  = v.addr;
         bus.mem_wdata = v.wdata;
         bus.mem_req   = 1'b1;
      end
      k = 0;
      seen = 1'b0;
      stall_ok = 1'b1;
      while (!seen && k < 40) begin
         @(negedge clk);
         k++;
         d = v.is_if ? bus.if_done : bus.mem_done;
         s = v.is_if ? bus.stall_req_if : bus.stall_req_mem;
         if (d) begin
            seen = 1'b1;
            if (s) stall_ok = 1'b0;
         end else if (!s) begin
            stall_ok = 1'b0;
         end
      end
      got = v.is_if ? bus.if_inst : bus.mem_rdata;
      chk($sformatf("v%0d_latency", id), 32'(k), 32'(v.lat));
      chk($sformatf("v%0d_stall", id), 32'(stall_ok), 32'd1);
      chk($sformatf("v%0d_data", id), got, v.exp);
      bus.if_req  = 1'b0;
      bus.mem_req = 1'b0;
      @(negedge clk);
      d   = v.is_if ? bus.if_done : bus.mem_done;
      got = v.is_if ? bus.if_inst : bus.mem_rdata;
      chk($sformatf("v%0d_pulse", id), 32'(d), 32'd0);
      chk($sformatf("v%0d_hold", id), got, v.exp);
      trace_ok = (alog.size() == n);
      for (int i = 0; i < n && i < alog.size(); i++)
         if (alog[i] != v.addr + 32'(i)) trace_ok = 1'b0;
      chk($sformatf("v%0d_addr_trace", id), 32'(trace_ok), 32'd1);
      if (v.we) begin
         wr_ok = (wlog.size() == n);
         for (int i = 0; i < n && i < wlog.size(); i++)
            if (wlog[i] != {v.addr + 32'(i), v.wdata[8*i +: 8]}) wr_ok = 1'b0;
      end else begin
         wr_ok = (wlog.size() == 0);
      end
      chk($sformatf("v%0d_write_trace", id), 32'(wr_ok), 32'd1);
   endtask

   initial begin
      int k;
      int mem_k;
      int if_k;
      bit ok;
      logic [31:0] mem_got;
      logic [31:0] if_got;

      bus.if_req = 1'b0;  bus.if_addr = '0;
      bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_len = '0;
      bus.mem_addr = '0;  bus.mem_wdata = '0;
      bus.io_buffer_full = 1'b0;

      //           is_if we   len    addr          wdata         exp           lat
      vecs[0]  = '{1'b1, 1'b0, 2'd3, 32'h0000_0100, 32'h0,        32'h0000_0513, 6};
      vecs[1]  = '{1'b0, 1'b0, 2'd0, 32'h0000_2001, 32'h0,        32'h0000_0080, 3};
      vecs[2]  = '{1'b0, 1'b0, 2'd1, 32'h0000_0100, 32'h0,        32'h0000_0513, 4};
      vecs[3]  = '{1'b0, 1'b0, 2'd3, 32'h0000_0200, 32'h0,        32'h4433_2211, 6};
      vecs[4]  = '{1'b0, 1'b1, 2'd1, 32'h0000_0040, 32'hAABB_CCDD, 32'h0,        3};
      vecs[5]  = '{1'b0, 1'b0, 2'd1, 32'h0000_0040, 32'h0,        32'h0000_CCDD, 4};
      vecs[6]  = '{1'b0, 1'b1, 2'd3, 32'h0000_0050, 32'h1234_5678, 32'h0,        5};
      vecs[7]  = '{1'b0, 1'b0, 2'd0, 32'h0000_0052, 32'h0,        32'h0000_0034, 3};
      vecs[8]  = '{1'b0, 1'b1, 2'd0, 32'h0000_2001, 32'h1234_56EF, 32'h0,        2};
      vecs[9]  = '{1'b0, 1'b0, 2'd3, 32'h0000_2000, 32'h0,        32'h0000_EF00, 6};
      vecs[10] = '{1'b1, 1'b0, 2'd3, 32'h0000_0050, 32'h0,        32'h1234_5678, 6};
      vecs[11] = '{1'b0, 1'b0, 2'd0, 32'h0000_0203, 32'h0,        32'h0000_0044, 3};
      vecs[12] = '{1'b0, 1'b0, 2'd0, 32'h0000_0060, 32'h0,        32'h0000_00BE, 3};
      vecs[13] = '{1'b0, 1'b0, 2'd0, 32'h0000_0061, 32'h0,        32'h0000_0000, 3};

      repeat (3) @(negedge clk);
      chk("rst_ram_a", bus.ram_a, 32'd0);
      chk("rst_ram_wr", 32'(bus.ram_wr), 32'd0);
      chk("rst_ram_dout", 32'(bus.ram_dout), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_if_done", 32'(bus.if_done), 32'd0);
      chk("reset_mem_done", 32'(bus.mem_done), 32'd0);
      chk("reset_if_inst", bus.if_inst, 32'd0);
      chk("reset_mem_rdata", bus.mem_rdata, 32'd0);
      chk("reset_stall", 32'({bus.stall_req_if, bus.stall_req_mem}), 32'd0);

      for (int i = 0; i < 12; i++) do_txn(vecs[i], i);

      // Simultaneous requests: MEM first, IF from the idle after MEM's done.
      bus.if_addr = 32'h100;  bus.if_req = 1'b1;
      bus.mem_we = 1'b0; bus.mem_len = 2'd3; bus.mem_addr = 32'h200; bus.mem_req = 1'b1;
      k = 0; mem_k = 0; if_k = 0; ok = 1'b1; mem_got = '0; if_got = '0;
      while (if_k == 0 && k < 60) begin
         @(negedge clk);
         k++;
         if (bus.mem_done && mem_k == 0) begin
            mem_k = k;
            mem_got = bus.mem_rdata;
            bus.mem_req = 1'b0;
         end
         if (bus.if_done) begin
            if_k = k;
            if_got = bus.if_inst;
            bus.if_req = 1'b0;
         end else if (!bus.stall_req_if) begin
            ok = 1'b0;
         end
      end
      chk("arb_mem_latency", 32'(mem_k), 32'd6);
      chk("arb_mem_data", mem_got, 32'h4433_2211);
      chk("arb_if_latency", 32'(if_k), 32'd13);
      chk("arb_if_data", if_got, 32'h0000_0513);
      chk("arb_stall_if", 32'(ok), 32'd1);
      @(negedge clk);

      // IO hold: full buffer for three cycles blocks the write.
      wlog.delete();
      bus.io_buffer_full = 1'b1;
      bus.mem_we = 1'b1; bus.mem_len = 2'd0; bus.mem_addr = 32'h3_0000;
      bus.mem_wdata = 32'h0000_0041; bus.mem_req = 1'b1;
      ok = 1'b1;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         if (bus.ram_wr !== 1'b0 || bus.ram_a !== 32'h3_0000 || bus.mem_done !== 1'b0) ok = 1'b0;
      end
      chk("io_hold_no_write", 32'(ok), 32'd1);
      @(posedge clk);
      #1 bus.io_buffer_full = 1'b0;
      @(negedge clk);
      chk("io_write_strobe", 32'(bus.ram_wr), 32'd1);
      chk("io_write_byte", 32'(bus.ram_dout), 32'h41);
      @(negedge clk);
      chk("io_mem_done", 32'(bus.mem_done), 32'd1);
      bus.mem_req = 1'b0;
      @(negedge clk);
      chk("io_one_write", 32'(wlog.size() == 1 && wlog[0] == {32'h3_0000, 8'h41}), 32'd1);

      // rdy low two cycles mid-fetch: done two cycles late, same word.
      bus.if_addr = 32'h50; bus.if_req = 1'b1;
      k = 0; ok = 1'b0;
      while (!ok && k < 40) begin
         @(negedge clk);
         k++;
         if (bus.if_done) ok = 1'b1;
         if (k == 2) rdy = 1'b0;
         if (k == 4) rdy = 1'b1;
      end
      chk("rdy_latency", 32'(k), 32'd8);
      chk("rdy_data", bus.if_inst, 32'h1234_5678);
      bus.if_req = 1'b0;
      rdy = 1'b1;
      @(negedge clk);

      // Reset during the second byte of a word store.
      wlog.delete();
      bus.mem_we = 1'b1; bus.mem_len = 2'd3; bus.mem_addr = 32'h60;
      bus.mem_wdata = 32'hCAFE_BABE; bus.mem_req = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst_mid_addr_before", bus.ram_a, 32'h61);
      rst = 1'b1;
      bus.mem_req = 1'b0;
      #1;
      chk("rst_mid_ram_wr", 32'(bus.ram_wr), 32'd0);
      chk("rst_mid_ram_a", bus.ram_a, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_mid_rdata_cleared", bus.mem_rdata, 32'd0);
      chk("rst_mid_if_inst_cleared", bus.if_inst, 32'd0);
      ok = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (bus.mem_done || bus.ram_wr || bus.if_done) ok = 1'b0;
      end
      chk("rst_mid_no_done", 32'(ok), 32'd1);
      chk("rst_mid_partial_write", 32'(wlog.size() == 1 && wlog[0] == {32'h60, 8'hBE}), 32'd1);

      do_txn(vecs[12], 12);
      do_txn(vecs[13], 13);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
